// File: rtl/pq_pkg.sv
// pq_pkg: shared priority-queue types, cell opcodes and the key priority compare
package pq_pkg;
  typedef enum logic {MIN_PQ, MAX_PQ} pq_type_t;
  typedef enum logic [1:0] {OP_HOLD, OP_ENQ, OP_DEQ, OP_REP} pq_op_t;
  typedef struct packed {
    logic [7:0] key;
    logic [7:0] val;
  } kv_t;
  localparam int PQ_KW_MAX = 64;
  function automatic logic pq_beats(input logic [PQ_KW_MAX-1:0] key_a, input logic [PQ_KW_MAX-1:0] key_b, input pq_type_t pq_type);
    return pq_type == MIN_PQ ? key_a < key_b : key_a > key_b;
  endfunction
endpackage

// File: rtl/pq_sr_cell.sv
// pq_sr_cell: one queue entry; from own/upper/lower contents, new pair and op it yields next contents and the insert-above flag for the cell below
module pq_sr_cell
  import pq_pkg::*;
#(
  parameter int KW = 8,
  parameter int VW = 8,
  parameter pq_type_t PQ_TYPE = MIN_PQ
) (
  input  pq_op_t           op,
  input  logic             ins_above,
  input  logic             self_v,
  input  logic [KW+VW-1:0] self_kv,
  input  logic             up_v,
  input  logic [KW+VW-1:0] up_kv,
  input  logic             lo_v,
  input  logic [KW+VW-1:0] lo_kv,
  input  logic [KW+VW-1:0] new_kv,
  output logic             nxt_v,
  output logic [KW+VW-1:0] nxt_kv,
  output logic             ins_below
);
  logic b_self, b_lo;
  assign b_self = !self_v || pq_beats(PQ_KW_MAX'(new_kv[KW+VW-1 -: KW]), PQ_KW_MAX'(self_kv[KW+VW-1 -: KW]), PQ_TYPE);
  assign b_lo = !lo_v || pq_beats(PQ_KW_MAX'(new_kv[KW+VW-1 -: KW]), PQ_KW_MAX'(lo_kv[KW+VW-1 -: KW]), PQ_TYPE);
  assign ins_below = ins_above | (op == OP_REP ? b_lo : b_self);
  always_comb begin
    {nxt_v, nxt_kv} = {self_v, self_kv};
    if (op == OP_ENQ)
      {nxt_v, nxt_kv} = ins_above ? {up_v, up_kv} : b_self ? {1'b1, new_kv} : {self_v, self_kv};
    else if (op == OP_DEQ)
      {nxt_v, nxt_kv} = {lo_v, lo_kv};
    else if (op == OP_REP)
      {nxt_v, nxt_kv} = ins_above ? {self_v, self_kv} : b_lo ? {1'b1, new_kv} : {lo_v, lo_kv};
  end
endmodule

// File: rtl/pq_sr_param.sv
// pq_sr_param: sorted shift-register priority queue; enq/deq/kvi in, head kvo, empty/full/count status, err pulse on illegal ops
module pq_sr_param
  import pq_pkg::*;
#(
  parameter int KEY_WIDTH = 8,
  parameter int VAL_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter pq_type_t PQ_TYPE = MIN_PQ,
  localparam int W = KEY_WIDTH + VAL_WIDTH,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enq,
  input  logic          deq,
  input  logic [W-1:0]  kvi,
  output logic [W-1:0]  kvo,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          err
);
  logic [DEPTH-1:0] v_q, v_d;
  logic [W-1:0] kv_q [DEPTH];
  logic [W-1:0] kv_d [DEPTH];
  logic [DEPTH+1:0] pv;
  logic [W-1:0] pkv [DEPTH+2];
  logic ins [DEPTH+1];
  pq_op_t op;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign kvo = v_q[0] ? kv_q[0] : '0;
  assign op = enq && deq ? (empty ? OP_ENQ : OP_REP) : enq ? (full ? OP_HOLD : OP_ENQ) : deq ? (empty ? OP_HOLD : OP_DEQ) : OP_HOLD;
  assign pv = {1'b0, v_q, 1'b0};
  assign pkv[0] = '0;
  assign pkv[DEPTH+1] = '0;
  assign ins[0] = 1'b0;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    assign pkv[i+1] = kv_q[i];
    pq_sr_cell #(.KW(KEY_WIDTH), .VW(VAL_WIDTH), .PQ_TYPE(PQ_TYPE)) u_cell (
      .op(op), .ins_above(ins[i]),
      .self_v(pv[i+1]), .self_kv(pkv[i+1]),
      .up_v(pv[i]), .up_kv(pkv[i]),
      .lo_v(pv[i+2]), .lo_kv(pkv[i+2]),
      .new_kv(kvi), .nxt_v(v_d[i]), .nxt_kv(kv_d[i]), .ins_below(ins[i+1])
    );
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      count <= '0;
      err <= 1'b0;
    end else begin
      v_q <= v_d;
      count <= op == OP_ENQ ? count + CW'(1) : op == OP_DEQ ? count - CW'(1) : count;
      err <= (enq && !deq && full) || (deq && empty);
    end
  end
  always_ff @(posedge clk) kv_q <= kv_d;
endmodule

// File: tb/tb_pq_sr_param.sv
// tb_pq_sr_param: directed and random checks of three queue instances against a sorted-list model
module tb_pq_sr_param;
  import pq_pkg::*;
  logic clk = 0, rst = 1;
  logic enq_a = 0, deq_a = 0, enq_b = 0, deq_b = 0, enq_c = 0, deq_c = 0;
  logic [15:0] kvi_a = 0, kvi_b = 0, kvo_a, kvo_b;
  logic [19:0] kvi_c = 0, kvo_c;
  logic [2:0] cnt_a, cnt_b;
  logic [4:0] cnt_c;
  logic emp_a, emp_b, emp_c, ful_a, ful_b, ful_c, err_a, err_b, err_c;
  int vectors = 0, miscompares = 0;
  int mq [3][$];
  int exp_tie [4] = '{2, 4, 1, 3};
  always #5 clk = ~clk;
  pq_sr_param #(.KEY_WIDTH(8), .VAL_WIDTH(8), .DEPTH(4), .PQ_TYPE(MIN_PQ)) dut_a (
    .clk(clk), .rst(rst), .enq(enq_a), .deq(deq_a), .kvi(kvi_a), .kvo(kvo_a),
    .empty(emp_a), .full(ful_a), .count(cnt_a), .err(err_a));
  pq_sr_param #(.KEY_WIDTH(8), .VAL_WIDTH(8), .DEPTH(4), .PQ_TYPE(MAX_PQ)) dut_b (
    .clk(clk), .rst(rst), .enq(enq_b), .deq(deq_b), .kvi(kvi_b), .kvo(kvo_b),
    .empty(emp_b), .full(ful_b), .count(cnt_b), .err(err_b));
  pq_sr_param #(.KEY_WIDTH(12), .VAL_WIDTH(8), .DEPTH(16), .PQ_TYPE(MIN_PQ)) dut_c (
    .clk(clk), .rst(rst), .enq(enq_c), .deq(deq_c), .kvi(kvi_c), .kvo(kvo_c),
    .empty(emp_c), .full(ful_c), .count(cnt_c), .err(err_c));
  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk(input int id, input bit eerr);
    logic [31:0] okvo;
    int ocnt, ecnt, dep;
    bit oe, of, oerr;
    case (id)
      0: begin okvo = 32'(kvo_a); ocnt = int'(cnt_a); oe = emp_a; of = ful_a; oerr = err_a; dep = 4; end
      1: begin okvo = 32'(kvo_b); ocnt = int'(cnt_b); oe = emp_b; of = ful_b; oerr = err_b; dep = 4; end
      default: begin okvo = 32'(kvo_c); ocnt = int'(cnt_c); oe = emp_c; of = ful_c; oerr = err_c; dep = 16; end
    endcase
    ecnt = mq[id].size();
    cmp($sformatf("kvo%0d", id), okvo, ecnt != 0 ? mq[id][0] : 0);
    cmp($sformatf("count%0d", id), ocnt, ecnt);
    cmp($sformatf("empty%0d", id), 32'(oe), 32'(ecnt == 0));
    cmp($sformatf("full%0d", id), 32'(of), 32'(ecnt == dep));
    cmp($sformatf("err%0d", id), 32'(oerr), 32'(eerr));
  endtask
  task automatic mdl(input int id, input bit e, input bit d, input int k, input int v, output bit er);
    int dep, pos;
    dep = id == 2 ? 16 : 4;
    er = 0;
    if (d && mq[id].size() == 0) begin er = 1; d = 0; end
    else if (e && !d && mq[id].size() == dep) begin er = 1; e = 0; end
    if (d) void'(mq[id].pop_front());
    if (e) begin
      pos = mq[id].size();
      for (int i = 0; i < mq[id].size(); i++)
        if (id == 1 ? k > (mq[id][i] >> 8) : k < (mq[id][i] >> 8)) begin pos = i; break; end
      mq[id].insert(pos, k * 256 + v);
    end
  endtask
  task automatic op(input int id, input bit e, input bit d, input int k, input int v);
    bit er;
    case (id)
      0: begin enq_a = e; deq_a = d; kvi_a = {k[7:0], v[7:0]}; end
      1: begin enq_b = e; deq_b = d; kvi_b = {k[7:0], v[7:0]}; end
      default: begin enq_c = e; deq_c = d; kvi_c = {k[11:0], v[7:0]}; end
    endcase
    @(posedge clk);
    #1;
    {enq_a, deq_a, enq_b, deq_b, enq_c, deq_c} = '0;
    mdl(id, e, d, k, v, er);
    chk(id, er);
  endtask
  task automatic burst(input int id, input int n, input int kmax);
    bit hi;
    int k;
    for (int i = 0; i < n; i++) begin
      hi = ((i / 400) % 2) == 0;
      k = (i % 700 < 350) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, kmax));
      op(id, $urandom_range(0, 9) < (hi ? 7 : 3), $urandom_range(0, 9) < (hi ? 3 : 7), k, i & 255);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 3; i++) chk(i, 0);
    cmp("rst_kvo", 32'(kvo_a), 0);
    op(0, 1, 0, 5, 1);
    op(0, 1, 0, 2, 2);
    op(0, 1, 0, 9, 3);
    op(0, 1, 0, 2, 4);
    cmp("tie_head", 32'(kvo_a), 32'h0202);
    for (int j = 0; j < 4; j++) begin
      cmp("tie_val", 32'(kvo_a[7:0]), exp_tie[j]);
      op(0, 0, 1, 0, 0);
    end
    op(0, 1, 0, 10, 1);
    op(0, 1, 0, 40, 4);
    op(0, 1, 0, 20, 2);
    op(0, 1, 0, 30, 3);
    op(0, 1, 0, 1, 5);
    cmp("full_err", 32'(err_a), 1);
    cmp("full_head", 32'(kvo_a), 32'h0A01);
    op(0, 1, 1, 0, 9);
    cmp("rep_head", 32'(kvo_a), 32'h0009);
    cmp("rep_count", 32'(cnt_a), 4);
    repeat (4) op(0, 0, 1, 0, 0);
    op(0, 0, 1, 0, 0);
    cmp("empty_err", 32'(err_a), 1);
    op(0, 1, 1, 7, 6);
    cmp("empty_rep_head", 32'(kvo_a), 32'h0706);
    cmp("empty_rep_err", 32'(err_a), 1);
    op(0, 1, 0, 0, 8);
    op(0, 1, 0, 255, 7);
    cmp("min_zero_head", 32'(kvo_a), 32'h0008);
    repeat (3) op(0, 0, 1, 0, 0);
    op(1, 1, 0, 255, 1);
    op(1, 1, 0, 0, 2);
    op(1, 1, 0, 255, 3);
    cmp("max_ff_head", 32'(kvo_b), 32'hFF01);
    repeat (3) op(1, 0, 1, 0, 0);
    burst(1, 2000, 255);
    burst(2, 10000, 4095);
    rst = 0;
    op(2, 1, 0, 100, 1);
    op(2, 1, 0, 50, 2);
    enq_c = 1;
    kvi_c = {12'd3, 8'd3};
    #3 rst = 1;
    #1;
    enq_c = 0;
    cmp("arst_count", 32'(cnt_c), 0);
    cmp("arst_empty", 32'(emp_c), 1);
    cmp("arst_full", 32'(ful_c), 0);
    cmp("arst_kvo", 32'(kvo_c), 0);
    cmp("arst_err", 32'(err_c), 0);
    for (int i = 0; i < 3; i++) mq[i].delete();
    #1 rst = 0;
    op(2, 1, 0, 77, 9);
    cmp("post_rst_count", 32'(cnt_c), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pq_sr_param.md
# pq_sr_param

Parametrised shift-register hardware priority queue: DEPTH registered entries kept sorted every cycle, head always visible at the output, single-cycle enqueue, dequeue and replace. It is the next-generation HWPQ core, and it generalises the fixed 8-bit MIN_PQ package settings into per-instance parameters. Per-entry valid bits replace sentinel keys, so every key value including all-ones and all-zeros is legal. Ties are stable (FIFO among equal keys), and illegal operations are reported.

## Interface
- KEY_WIDTH, 8, key (priority) width in bits
- VAL_WIDTH, 8, value payload width in bits
- DEPTH, 16, number of entries; legal range 2..1024
- PQ_TYPE, MIN_PQ, MIN_PQ: smallest key is highest priority; MAX_PQ: largest key is highest priority
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- enq  in  1  enqueue kvi this cycle
- deq  in  1  dequeue head this cycle
- kvi  in  KEY_WIDTH+VAL_WIDTH  input pair, key in the MSBs, value in the LSBs
- kvo  out  KEY_WIDTH+VAL_WIDTH  head pair (entry 0); all-zero when empty
- empty  out  1  no valid entries
- full  out  1  DEPTH valid entries
- count  out  $clog2(DEPTH+1)  number of valid entries
- err  out  1  one-cycle pulse on an illegal operation

## Operation
- Storage: entries 0..DEPTH-1, each {valid, key, value}.
  - Entry 0 is the highest priority.
  - Valid entries are contiguous from entry 0.
  - Invalid entries are lower priority than any key.
- beats(a,b): strict priority comparison, a.key < b.key for MIN_PQ, > for MAX_PQ. Equal keys never beat each other, so a newer equal key lands behind older ones.
- Enqueue only (enq=1, deq=0, not full):
  - Insert position p = lowest index where the entry is invalid or kvi beats it.
  - Entries p..DEPTH-2 shift down one place; kvi is written at p; count+1.
- Dequeue only (deq=1, enq=0, not empty): entries 1..DEPTH-1 shift up one place; the last entry becomes invalid; count-1.
- Replace (enq=1, deq=1, not empty):
  - The head is removed and kvi is inserted in the same cycle.
  - The result equals a dequeue followed by an enqueue; count is unchanged.
  - Replace is legal when full.
- Illegal cases; state is unchanged unless stated:
  - enq with full and no deq: kvi is dropped and err pulses.
  - deq with empty and no enq: err pulses.
  - enq and deq with empty: the operation is performed as an enqueue only (count becomes 1) and err pulses for the failed dequeue.
- No operation: state holds and err=0.

## Timing
- Reset (asynchronous assert): all valid bits 0, count=0, empty=1, full=0, kvo=0, err=0. Key and value storage need not be reset.
- All operations take one cycle. kvo, count, empty, full and err reflect the operation in the cycle after the edge that samples enq/deq.
- Back-to-back operations every cycle are supported; there is no busy signal.
- kvo, empty, full and count are decoded from registered state only and have no combinational path from inputs. err is a registered pulse.
- The critical path is the DEPTH parallel comparators plus a one-hot position select. A pipelined variant is out of scope.
- If reset asserts mid-stream, the contents are discarded immediately. The first operation after deassertion sees an empty queue.

## Structure
- pq_type_t (MIN_PQ/MAX_PQ) stays in pq_pkg. Add a function pq_beats(key_a, key_b, pq_type) to pq_pkg, generic over width by taking the key width as a module-local parameter at the call site. The fixed kv_t stays in pq_pkg for legacy blocks.
- This module uses local packed vectors sized by KEY_WIDTH and VAL_WIDTH.
- Sub-module pq_sr_cell: one entry. Inputs are its own, upper and lower neighbour contents, the new pair, and a shared control (op, insert-above flag). Output is the next contents plus the beats flag passed to the cell below. The top level instantiates DEPTH cells with generate, plus the count and error logic.

## Test plan
- Reset, MIN_PQ, DEPTH=4 -> empty=1, count=0, kvo=0. Enqueue keys 5,2,9,2 (values 1,2,3,4) -> kvo={2,2}. Successive dequeues give values 2,4,1,3, proving stable ties.
- Full, DEPTH=4: enqueue a 5th pair -> err pulse, contents unchanged, full=1. Replace with key 0 -> kvo key 0, count=4, err=0.
- Empty: deq alone -> err pulse, count 0. enq+deq with key 7 -> count=1, kvo key 7, err pulse.
- MAX_PQ with key 255 and MIN_PQ with key 0 (former sentinel values) -> stored and dequeued correctly, proving no sentinel restriction.
- Random stress, DEPTH=16, KEY_WIDTH=12, 10k mixed enq/deq/replace cycles against a sorted-list scoreboard -> kvo, count, full, empty and err match every cycle.
- Asynchronous reset asserted mid-burst between clock edges -> outputs reach reset values before the next edge. The next enqueue after deassertion gives count=1.
